// File: rtl/mmio_requester_pkg.sv
// Shared widths, the read-tracking tag type and a tag constructor for the MMIO requester.
package mmio_requester_pkg;

  localparam int MMIO_ADDR_WIDTH    = 16;
  localparam int MMIO_DATA_WIDTH    = 64;
  // Tags hold TIDs up to this width; narrower TIDs are zero-extended.
  localparam int MMIO_TID_WIDTH_MAX = 16;

  typedef struct packed {
    logic [MMIO_TID_WIDTH_MAX-1:0] tid;
    logic [MMIO_ADDR_WIDTH-1:0]    addr;
  } t_mmio_tag;

  function automatic t_mmio_tag mk_tag(input logic [MMIO_TID_WIDTH_MAX-1:0] tid,
                                       input logic [MMIO_ADDR_WIDTH-1:0]    addr);
    t_mmio_tag t;
    t.tid  = tid;
    t.addr = addr;
    return t;
  endfunction

endpackage

// File: rtl/mmio_requester_if.sv
// Command, MMIO request/response and status bundle; master = requester side, slave = user/responder side.
interface mmio_requester_if
  import mmio_requester_pkg::*;
#(
  parameter int TID_WIDTH = 9,
  parameter int CNT_WIDTH = 3
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_wr;
  logic [MMIO_ADDR_WIDTH-1:0] cmd_addr;
  logic [MMIO_DATA_WIDTH-1:0] cmd_wdata;

  logic                       mmio_wr_valid;
  logic                       mmio_rd_valid;
  logic [MMIO_ADDR_WIDTH-1:0] mmio_addr;
  logic [TID_WIDTH-1:0]       mmio_tid;
  logic [MMIO_DATA_WIDTH-1:0] mmio_wdata;

  logic                       rsp_valid;
  logic [TID_WIDTH-1:0]       rsp_tid;
  logic [MMIO_DATA_WIDTH-1:0] rsp_data;

  logic                       rd_valid;
  logic [MMIO_ADDR_WIDTH-1:0] rd_addr;
  logic [MMIO_DATA_WIDTH-1:0] rd_data;
  logic [CNT_WIDTH-1:0]       outstanding;
  logic                       err_tid;
  logic                       err_timeout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_valid, rsp_tid, rsp_data,
    output cmd_ready, mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
           rd_valid, rd_addr, rd_data, outstanding, err_tid, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_valid, rsp_tid, rsp_data,
    input  cmd_ready, mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
           rd_valid, rd_addr, rd_data, outstanding, err_tid, err_timeout
  );

endinterface

// File: rtl/mmio_tag_fifo.sv
// In-order tag FIFO for outstanding reads: first-word fall-through head, occupancy count,
// simultaneous push and pop.
module mmio_tag_fifo
  import mmio_requester_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  t_mmio_tag              push_data_i,
  input  logic                   pop_i,
  output t_mmio_tag              head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  t_mmio_tag       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push_s, do_pop_s;

  // Pointer and occupancy next-state.
  always_comb begin
    do_push_s = push_i && (count_q != (AW+1)'(DEPTH));
    do_pop_s  = pop_i && (count_q != '0);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mmio_requester.sv
// MMIO initiator: issues registered write/read requests with rolling TIDs, matches in-order
// read responses, and flags TID errors. Read timeout is built only with MMIO_REQUESTER_TIMEOUT_EN.
module mmio_requester
  import mmio_requester_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TID_WIDTH       = 9
) (
  input  logic        clk,
  input  logic        rst,
  mmio_requester_if.master bus
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

  if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of two >= 2");
  end
  if ((TIMEOUT_CYCLES < 1) || (TID_WIDTH > MMIO_TID_WIDTH_MAX)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be >= 1 and TID_WIDTH must fit the tag");
  end

  logic                       cmd_ready_s, cmd_fire_s, push_s, pop_s, tid_hit_s, empty_s;
  logic                       err_timeout_s;
  t_mmio_tag                  head_s;
  logic [CNT_WIDTH-1:0]       count_s;

  logic [TID_WIDTH-1:0]       tid_ctr_q, tid_ctr_d;
  logic                       mmio_wr_valid_q, mmio_wr_valid_d;
  logic                       mmio_rd_valid_q, mmio_rd_valid_d;
  logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_q, mmio_addr_d;
  logic [TID_WIDTH-1:0]       mmio_tid_q, mmio_tid_d;
  logic [MMIO_DATA_WIDTH-1:0] mmio_wdata_q, mmio_wdata_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [MMIO_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [MMIO_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                       err_tid_q, err_tid_d;

  mmio_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (mk_tag(MMIO_TID_WIDTH_MAX'(tid_ctr_q), bus.cmd_addr)),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (empty_s),
    .count_o     (count_s)
  );

  // Command acceptance, request issue and response matching.
  always_comb begin
    cmd_ready_s = !err_tid_q && !err_timeout_s &&
                  (bus.cmd_wr || (count_s < CNT_WIDTH'(MAX_OUTSTANDING)));
    cmd_fire_s  = bus.cmd_valid && cmd_ready_s;
    push_s      = cmd_fire_s && !bus.cmd_wr;
    pop_s       = bus.rsp_valid && !empty_s;
    tid_hit_s   = (head_s.tid == MMIO_TID_WIDTH_MAX'(bus.rsp_tid));

    tid_ctr_d       = tid_ctr_q;
    mmio_wr_valid_d = 1'b0;
    mmio_rd_valid_d = 1'b0;
    mmio_addr_d     = '0;
    mmio_tid_d      = '0;
    mmio_wdata_d    = '0;
    rd_valid_d      = 1'b0;
    rd_addr_d       = '0;
    rd_data_d       = '0;
    err_tid_d       = err_tid_q;

    if (cmd_fire_s) begin
      mmio_addr_d = bus.cmd_addr;
      if (bus.cmd_wr) begin
        mmio_wr_valid_d = 1'b1;
        mmio_wdata_d    = bus.cmd_wdata;
      end else begin
        mmio_rd_valid_d = 1'b1;
        mmio_tid_d      = tid_ctr_q;
        tid_ctr_d       = tid_ctr_q + TID_WIDTH'(1);
      end
    end else begin
      tid_ctr_d = tid_ctr_q;
    end

    // An unmatched or unexpected response is still consumed, just not delivered.
    if (bus.rsp_valid) begin
      if (!empty_s && tid_hit_s) begin
        rd_valid_d = 1'b1;
        rd_addr_d  = head_s.addr;
        rd_data_d  = bus.rsp_data;
      end else begin
        err_tid_d = 1'b1;
      end
    end else begin
      err_tid_d = err_tid_q;
    end
  end

  // Request, read-return and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tid_ctr_q       <= '0;
      mmio_wr_valid_q <= 1'b0;
      mmio_rd_valid_q <= 1'b0;
      mmio_addr_q     <= '0;
      mmio_tid_q      <= '0;
      mmio_wdata_q    <= '0;
      rd_valid_q      <= 1'b0;
      rd_addr_q       <= '0;
      rd_data_q       <= '0;
      err_tid_q       <= 1'b0;
    end else begin
      tid_ctr_q       <= tid_ctr_d;
      mmio_wr_valid_q <= mmio_wr_valid_d;
      mmio_rd_valid_q <= mmio_rd_valid_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_tid_q      <= mmio_tid_d;
      mmio_wdata_q    <= mmio_wdata_d;
      rd_valid_q      <= rd_valid_d;
      rd_addr_q       <= rd_addr_d;
      rd_data_q       <= rd_data_d;
      err_tid_q       <= err_tid_d;
    end
  end

`ifdef MMIO_REQUESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_timeout_q, err_timeout_d;

  // Age of the oldest outstanding read; saturates so it cannot wrap past the limit.
  always_comb begin
    err_timeout_d = err_timeout_q;
    if (empty_s || pop_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_d == TW'(TIMEOUT_CYCLES)) begin
        err_timeout_d = 1'b1;
      end else begin
        err_timeout_d = err_timeout_q;
      end
    end
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout_s = err_timeout_q;
`else
  assign err_timeout_s = 1'b0;
`endif

  assign bus.cmd_ready     = cmd_ready_s;
  assign bus.mmio_wr_valid = mmio_wr_valid_q;
  assign bus.mmio_rd_valid = mmio_rd_valid_q;
  assign bus.mmio_addr     = mmio_addr_q;
  assign bus.mmio_tid      = mmio_tid_q;
  assign bus.mmio_wdata    = mmio_wdata_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.outstanding   = count_s;
  assign bus.err_tid       = err_tid_q;
  assign bus.err_timeout   = err_timeout_s;

endmodule
